// File: rtl/labfinal_soc_pio_pkg.sv
// Shared constants for the labfinal SoC parallel I/O slave: register map and edge-capture modes.
package labfinal_soc_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/labfinal_soc_pio_edge_det.sv
// Input synchroniser and per-bit edge detector with a post-reset priming guard.
module labfinal_soc_pio_edge_det
  import labfinal_soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_c
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] term;
  logic [1:0]       prime_cnt;
  logic             armed;

  // armed trails the saturated counter by one cycle so prev has caught up with
  // the first real sample before any edge term is allowed through
  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      prime_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      s1    <= in_port;
      s2    <= s1;
      prev  <= s2;
      armed <= (prime_cnt == 2'd2);
      if (prime_cnt != 2'd2) begin
        prime_cnt <= prime_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    rise = s2 & ~prev;
    fall = ~s2 & prev;
    if (EDGE_TYPE == EDGE_RISE) begin
      term = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      term = fall;
    end else begin
      term = rise | fall;
    end
  end

  assign sync   = s2;
  assign edge_c = armed ? term : '0;

endmodule

// File: rtl/labfinal_soc_pio_irq.sv
// Avalon-MM PIO slave: set/clear output register, synchronised input with edge capture and masked level irq.
module labfinal_soc_pio_irq
  import labfinal_soc_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BUS_W-1:0]  writedata,
  output logic [BUS_W-1:0]  readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_next;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  labfinal_soc_pio_edge_det #(
    .WIDTH    (WIDTH),
    .EDGE_TYPE(EDGE_TYPE)
  ) u_edge_det (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .sync   (sync),
    .edge_c (edge_c)
  );

  assign cap_clr = (wr && (address == ADDR_EDGECAP)) ? wdata : '0;

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next = sync;
      ADDR_OUT:     rd_next = out_reg;
      ADDR_IRQMASK: rd_next = irqmask;
      ADDR_EDGECAP: rd_next = edgecap;
      default:      rd_next = '0;
    endcase
  end

  // Register file; a fresh edge overrides a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg  <= RESET_VALUE;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_DATA, ADDR_OUT: out_reg <= wdata;
          ADDR_OUTSET:         out_reg <= out_reg | wdata;
          ADDR_OUTCLR:         out_reg <= out_reg & ~wdata;
          ADDR_IRQMASK:        irqmask <= wdata;
          default:             ;
        endcase
      end
      edgecap  <= (edgecap & ~cap_clr) | edge_c;
      readdata <= BUS_W'(rd_next);
    end
  end

  assign out_port = out_reg;
  assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_labfinal_soc_pio_irq.sv
// Directed bench for labfinal_soc_pio_irq: a rising-edge instance and an any-edge instance on one bus.
module tb_labfinal_soc_pio_irq;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic        irq_a;
  logic        irq_b;

  int total;
  int bad;

  logic [31:0] ra;
  logic [31:0] rb;

  labfinal_soc_pio_irq #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .irq(irq_a)
  );

  labfinal_soc_pio_irq #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .out_port(out_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] da, output logic [31:0] db);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    da = rd_a;
    db = rd_b;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    in_a  = 8'hFF;
    in_b  = 8'hFF;
    reset = 1'b1;
    ticks(2);
    total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want %h", rd_a, 32'h0); end
    total++; if (out_a !== 8'hA5) begin bad++; $display("FAIL reset_out_a: got %h want %h", out_a, 8'hA5); end
    total++; if (out_b !== 8'h00) begin bad++; $display("FAIL reset_out_b: got %h want %h", out_b, 8'h00); end
    reset = 1'b0;
    ticks(6);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq_a); end
    bus_read(3'd3, ra, rb);
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL reset_edgecap_a: got %h want %h", ra, 32'h0); end
    total++; if (rb !== 32'h0) begin bad++; $display("FAIL reset_edgecap_b: got %h want %h", rb, 32'h0); end
  endtask

  task automatic test_out_setclr();
    bus_write(3'd1, 32'h0000_000F);
    total++; if (out_a !== 8'h0F) begin bad++; $display("FAIL out_write: got %h want %h", out_a, 8'h0F); end
    bus_write(3'd4, 32'h0000_00F0);
    total++; if (out_a !== 8'hFF) begin bad++; $display("FAIL out_set: got %h want %h", out_a, 8'hFF); end
    bus_write(3'd5, 32'hFFFF_FF81);
    total++; if (out_a !== 8'h7E) begin bad++; $display("FAIL out_clr: got %h want %h", out_a, 8'h7E); end
    bus_read(3'd1, ra, rb);
    total++; if (ra !== 32'h0000_007E) begin bad++; $display("FAIL out_read: got %h want %h", ra, 32'h7E); end
  endtask

  task automatic test_edge_irq();
    in_a = 8'h00;
    ticks(5);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h04);
    in_a = 8'h04;
    tick();
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL edge_irq_e1: got %b want 0", irq_a); end
    tick();
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL edge_irq_e2: got %b want 0", irq_a); end
    tick();
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL edge_irq_e3: got %b want 1", irq_a); end
    bus_read(3'd3, ra, rb);
    total++; if (ra !== 32'h04) begin bad++; $display("FAIL edge_cap_bit2: got %h want %h", ra, 32'h04); end
    bus_write(3'd3, 32'h04);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL edge_clear_irq: got %b want 0", irq_a); end
    in_a = 8'h0C;
    ticks(5);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL edge_masked_irq: got %b want 0", irq_a); end
    bus_read(3'd3, ra, rb);
    total++; if (ra !== 32'h08) begin bad++; $display("FAIL edge_cap_bit3: got %h want %h", ra, 32'h08); end
  endtask

  task automatic test_clear_collision();
    in_a = 8'h08;
    ticks(5);
    bus_write(3'd3, 32'hFF);
    in_a = 8'h0C;
    ticks(2);
    bus_write(3'd3, 32'h04);
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL collide_irq: got %b want 1", irq_a); end
    bus_read(3'd3, ra, rb);
    total++; if (ra !== 32'h04) begin bad++; $display("FAIL collide_edgecap: got %h want %h", ra, 32'h04); end
    bus_write(3'd3, 32'h04);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL second_clear_irq: got %b want 0", irq_a); end
  endtask

  task automatic test_any_edge();
    bus_write(3'd3, 32'hFF);
    in_b = 8'hFE;
    in_a = 8'h04;
    ticks(5);
    bus_read(3'd3, ra, rb);
    total++; if (rb !== 32'h01) begin bad++; $display("FAIL any_fall_b: got %h want %h", rb, 32'h01); end
    total++; if (ra !== 32'h00) begin bad++; $display("FAIL rise_ignores_fall_a: got %h want %h", ra, 32'h00); end
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL any_masked_irq_b: got %b want 0", irq_b); end
    bus_write(3'd3, 32'hFF);
    in_b = 8'hFF;
    ticks(5);
    bus_read(3'd3, ra, rb);
    total++; if (rb !== 32'h01) begin bad++; $display("FAIL any_rise_b: got %h want %h", rb, 32'h01); end
    bus_read(3'd4, ra, rb);
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL read_addr4: got %h want %h", ra, 32'h0); end
    bus_read(3'd6, ra, rb);
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL read_addr6: got %h want %h", ra, 32'h0); end
    bus_read(3'd7, ra, rb);
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL read_addr7: got %h want %h", ra, 32'h0); end
    bus_read(3'd0, ra, rb);
    total++; if (ra !== 32'h04) begin bad++; $display("FAIL read_data_sync: got %h want %h", ra, 32'h04); end
  endtask

  task automatic test_reset_mid();
    bus_write(3'd1, 32'h3C);
    in_a = 8'h00;
    ticks(5);
    bus_write(3'd3, 32'hFF);
    in_a = 8'hFF;
    ticks(5);
    bus_read(3'd3, ra, rb);
    total++; if (ra !== 32'hFF) begin bad++; $display("FAIL mid_pre_edgecap: got %h want %h", ra, 32'hFF); end
    reset      = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd1;
    writedata  = 32'h55;
    tick();
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    total++; if (out_a !== 8'hA5) begin bad++; $display("FAIL mid_out: got %h want %h", out_a, 8'hA5); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL mid_irq: got %b want 0", irq_a); end
    total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL mid_readdata: got %h want %h", rd_a, 32'h0); end
    ticks(5);
    bus_read(3'd3, ra, rb);
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL mid_edgecap: got %h want %h", ra, 32'h0); end
    bus_read(3'd2, ra, rb);
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL mid_irqmask: got %h want %h", ra, 32'h0); end
    total++; if (out_a !== 8'hA5) begin bad++; $display("FAIL mid_write_dropped: got %h want %h", out_a, 8'hA5); end
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_a       = 8'hFF;
    in_b       = 8'hFF;
    total      = 0;
    bad        = 0;
    test_reset();
    test_out_setclr();
    test_edge_irq();
    test_clear_collision();
    test_any_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
